// File: rtl/prq_sched_if.sv
// Signal bundle between the PRQ front-end scheduler, its request sources,
// the PRQ itself and the match/unexpected consumers.
interface prq_sched_if #(
  parameter int MSG_WIDTH = 128
);
  logic                 proc_req_valid;
  logic                 proc_req_ready;
  logic [31:0]          proc_request;
  logic [31:0]          proc_data_ptr;
  logic                 net_msg_valid;
  logic                 net_msg_ready;
  logic [MSG_WIDTH-1:0] net_msg;
  logic                 prq_insert;
  logic                 prq_find;
  logic [31:0]          prq_request;
  logic [31:0]          prq_data_ptr;
  logic [MSG_WIDTH-1:0] prq_message;
  logic                 prq_found;
  logic                 prq_not_found;
  logic                 prq_full;
  logic [31:0]          prq_posted_request;
  logic                 match_valid;
  logic                 match_ready;
  logic [31:0]          match_request;
  logic [MSG_WIDTH-1:0] match_message;
  logic                 unexp_valid;
  logic                 unexp_ready;
  logic [MSG_WIDTH-1:0] unexp_message;
  logic                 busy;
  logic                 err_timeout;

  modport master (
    input  proc_req_valid, proc_request, proc_data_ptr,
    input  net_msg_valid, net_msg,
    input  prq_found, prq_not_found, prq_full, prq_posted_request,
    input  match_ready, unexp_ready,
    output proc_req_ready, net_msg_ready,
    output prq_insert, prq_find, prq_request, prq_data_ptr, prq_message,
    output match_valid, match_request, match_message,
    output unexp_valid, unexp_message,
    output busy, err_timeout
  );

  modport slave (
    output proc_req_valid, proc_request, proc_data_ptr,
    output net_msg_valid, net_msg,
    output prq_found, prq_not_found, prq_full, prq_posted_request,
    output match_ready, unexp_ready,
    input  proc_req_ready, net_msg_ready,
    input  prq_insert, prq_find, prq_request, prq_data_ptr, prq_message,
    input  match_valid, match_request, match_message,
    input  unexp_valid, unexp_message,
    input  busy, err_timeout
  );
endinterface

// File: rtl/prq_sched.sv
// PRQ front-end scheduler: round-robin between processor receives and network
// headers, one PRQ operation at a time, routing find results to match/unexpected.
module prq_sched #(
  parameter int MSG_WIDTH    = 128,
  parameter int INSERT_GAP   = 6,
  parameter int FIND_TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        rst,
  prq_sched_if.master bus
);
  localparam int GAP_W = $clog2(INSERT_GAP + 1);
  localparam int FTO_W = $clog2(FIND_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(INSERT_GAP - 1);
  localparam logic [FTO_W-1:0] FTO_MAX  = FTO_W'(FIND_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_INS_ISSUE, S_INS_WAIT, S_FIND_ISSUE, S_FIND_WAIT, S_MATCH_OUT, S_UNEXP_OUT
  } state_t;

  state_t               r_state;
  logic                 r_last_net;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic [FTO_W-1:0]     r_find_cnt;
  logic                 r_insert;
  logic                 r_find;
  logic [31:0]          r_request;
  logic [31:0]          r_data_ptr;
  logic [MSG_WIDTH-1:0] r_message;
  logic [31:0]          r_match_request;
  logic                 r_match_valid;
  logic                 r_unexp_valid;
  logic                 r_busy;
  logic                 r_err_timeout;

  logic w_proc_elig, w_net_elig, w_gnt_proc, w_gnt_net, w_idle;
  logic w_proc_xfer, w_net_xfer;

  // A full PRQ only holds back inserts; on a tie the source not served last wins.
  assign w_proc_elig = bus.proc_req_valid && !bus.prq_full;
  assign w_net_elig  = bus.net_msg_valid;
  assign w_gnt_proc  = w_proc_elig && (!w_net_elig || r_last_net);
  assign w_gnt_net   = w_net_elig && (!w_proc_elig || !r_last_net);
  assign w_idle      = (r_state == S_IDLE) && !rst;

  assign bus.proc_req_ready = w_idle && w_gnt_proc;
  assign bus.net_msg_ready  = w_idle && w_gnt_net;
  assign w_proc_xfer        = bus.proc_req_valid && bus.proc_req_ready;
  assign w_net_xfer         = bus.net_msg_valid && bus.net_msg_ready;

  assign bus.prq_insert    = r_insert;
  assign bus.prq_find      = r_find;
  assign bus.prq_request   = r_request;
  assign bus.prq_data_ptr  = r_data_ptr;
  assign bus.prq_message   = r_message;
  assign bus.match_valid   = r_match_valid;
  assign bus.match_request = r_match_request;
  assign bus.match_message = r_message;
  assign bus.unexp_valid   = r_unexp_valid;
  assign bus.unexp_message = r_message;
  assign bus.busy          = r_busy;
  assign bus.err_timeout   = r_err_timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_last_net      <= 1'b1;
      r_gap_cnt       <= '0;
      r_find_cnt      <= '0;
      r_insert        <= 1'b0;
      r_find          <= 1'b0;
      r_request       <= '0;
      r_data_ptr      <= '0;
      r_message       <= '0;
      r_match_request <= '0;
      r_match_valid   <= 1'b0;
      r_unexp_valid   <= 1'b0;
      r_busy          <= 1'b0;
      r_err_timeout   <= 1'b0;
    end else begin
      r_insert      <= 1'b0;
      r_find        <= 1'b0;
      r_err_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_proc_xfer) begin
            r_request  <= bus.proc_request;
            r_data_ptr <= bus.proc_data_ptr;
            r_last_net <= 1'b0;
            r_insert   <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_INS_ISSUE;
          end else if (w_net_xfer) begin
            r_message  <= bus.net_msg;
            r_last_net <= 1'b1;
            r_find     <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_FIND_ISSUE;
          end
        end
        S_INS_ISSUE: begin
          r_gap_cnt <= '0;
          r_state   <= S_INS_WAIT;
        end
        S_INS_WAIT: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        S_FIND_ISSUE: begin
          r_find_cnt <= '0;
          r_state    <= S_FIND_WAIT;
        end
        // found takes priority over not_found; a silent PRQ drops the message
        S_FIND_WAIT: begin
          if (bus.prq_found) begin
            r_match_request <= bus.prq_posted_request;
            r_match_valid   <= 1'b1;
            r_state         <= S_MATCH_OUT;
          end else if (bus.prq_not_found) begin
            r_unexp_valid <= 1'b1;
            r_state       <= S_UNEXP_OUT;
          end else if (r_find_cnt == FTO_MAX) begin
            r_err_timeout <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_find_cnt <= r_find_cnt + FTO_W'(1);
          end
        end
        S_MATCH_OUT: begin
          if (bus.match_ready) begin
            r_match_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        S_UNEXP_OUT: begin
          if (bus.unexp_ready) begin
            r_unexp_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_prq_sched.sv
// Scoreboard bench for prq_sched: queued drivers, a behavioural PRQ and a
// reference list of posted receives predicting every scheduler outcome.
module tb_prq_sched;
  localparam int MW  = 128;
  localparam int GAP = 6;
  localparam int FTO = 8;
  localparam int K_MATCH = 0, K_UNEXP = 1, K_ERR = 2;

  typedef struct { logic [31:0] req; logic [31:0] ptr; } ins_t;
  typedef struct { int kind; logic [31:0] req; logic [MW-1:0] msg; } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prq_sched_if #(.MSG_WIDTH(MW)) bus ();
  prq_sched #(.MSG_WIDTH(MW), .INSERT_GAP(GAP), .FIND_TIMEOUT(FTO)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  ins_t proc_q[$], exp_ins[$];
  logic [MW-1:0] net_q[$], exp_find[$];
  out_t exp_out[$];
  logic [31:0] ref_posted[$], prq_mem[$];
  int grant_log[$];
  int ready_mode = 2;
  logic prq_silent = 1'b0;
  logic find_pending = 1'b0;
  int ins_free = 0, acc_cyc = 0, net_acc_cyc = 0, find_cyc = 0, resp_cyc = 0;
  int ins_pulses = 0, find_pulses = 0, err_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string name, string why);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s (cycle %0d)", name, why, cyc);
  endtask

  function automatic logic [MW-1:0] mk_msg(logic [7:0] c, logic [7:0] s, logic [7:0] t);
    logic [MW-1:0] m;
    m = {$urandom, $urandom, $urandom, $urandom};
    m[111:104] = c;
    m[103:96]  = s;
    m[95:88]   = t;
    return m;
  endfunction

  function automatic int find_ref(logic [23:0] k);
    for (int i = 0; i < ref_posted.size(); i++)
      if (ref_posted[i][23:0] == k) return i;
    return -1;
  endfunction

  task automatic push_proc(logic [31:0] r, logic [31:0] p);
    ins_t x;
    x.req = r;
    x.ptr = p;
    proc_q.push_back(x);
  endtask

  // Processor source: presents queued receives, holds each until accepted.
  initial begin : proc_drv
    int w;
    bus.proc_req_valid = 1'b0;
    bus.proc_request   = '0;
    bus.proc_data_ptr  = '0;
    forever begin
      @(posedge clk); #1;
      while (proc_q.size() > 0) begin
        bus.proc_req_valid = 1'b1;
        bus.proc_request   = proc_q[0].req;
        bus.proc_data_ptr  = proc_q[0].ptr;
        w = 0;
        while (1) begin
          @(negedge clk);
          if (bus.proc_req_ready) break;
          w++;
          if (w > 3000) break;
        end
        if (w > 3000) fail_now("proc_accept_timeout", "processor request never accepted");
        @(posedge clk); #1;
        void'(proc_q.pop_front());
      end
      bus.proc_req_valid = 1'b0;
    end
  end

  initial begin : net_drv
    int w;
    bus.net_msg_valid = 1'b0;
    bus.net_msg       = '0;
    forever begin
      @(posedge clk); #1;
      while (net_q.size() > 0) begin
        bus.net_msg_valid = 1'b1;
        bus.net_msg       = net_q[0];
        w = 0;
        while (1) begin
          @(negedge clk);
          if (bus.net_msg_ready) break;
          w++;
          if (w > 3000) break;
        end
        if (w > 3000) fail_now("net_accept_timeout", "network message never accepted");
        @(posedge clk); #1;
        void'(net_q.pop_front());
      end
      bus.net_msg_valid = 1'b0;
    end
  end

  initial begin : out_drv
    bus.match_ready = 1'b0;
    bus.unexp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: begin
          bus.match_ready = 1'($urandom_range(0, 1));
          bus.unexp_ready = 1'($urandom_range(0, 1));
        end
        1: begin bus.match_ready = 1'b0; bus.unexp_ready = 1'b0; end
        default: begin bus.match_ready = 1'b1; bus.unexp_ready = 1'b1; end
      endcase
    end
  end

  // Behavioural PRQ: oldest matching entry wins; misses answer one cycle after the find.
  initial begin : prq_model
    int lat, hit;
    bus.prq_found = 1'b0;
    bus.prq_not_found = 1'b0;
    bus.prq_posted_request = '0;
    forever begin
      @(posedge clk); #1;
      bus.prq_found = 1'b0;
      bus.prq_not_found = 1'b0;
      if (bus.prq_insert) prq_mem.push_back(bus.prq_request);
      if (bus.prq_find && !prq_silent) begin
        hit = -1;
        for (int i = 0; i < prq_mem.size(); i++)
          if (hit < 0 && prq_mem[i][23:0] == bus.prq_message[111:88]) hit = i;
        lat = (hit < 0) ? 1 : int'($urandom_range(1, 4));
        repeat (lat) @(posedge clk);
        #1;
        resp_cyc = cyc;
        if (hit >= 0) begin
          bus.prq_found = 1'b1;
          bus.prq_not_found = ($urandom_range(0, 3) == 0);
          bus.prq_posted_request = prq_mem[hit];
          prq_mem.delete(hit);
        end else begin
          bus.prq_not_found = 1'b1;
          bus.prq_posted_request = $urandom;
        end
      end
    end
  end

  logic prev_mv = 0, prev_mhs = 0, prev_uv = 0, prev_uhs = 0, prev_err = 0;
  logic [31:0] prev_mreq;
  logic [MW-1:0] prev_mmsg, prev_umsg;

  always @(negedge clk) begin : mon
    out_t e;
    ins_t x;
    int idx;
    if (rst) begin
      exp_out.delete();
      exp_ins.delete();
      exp_find.delete();
      find_pending = 1'b0;
      prev_mv = 0; prev_mhs = 0; prev_uv = 0; prev_uhs = 0; prev_err = 0;
    end else begin
      if (bus.prq_full && bus.proc_req_valid) check("ready_while_full", bus.proc_req_ready, 0);
      if (bus.proc_req_valid && bus.net_msg_valid)
        check("single_grant", bus.proc_req_ready && bus.net_msg_ready, 0);
      if (bus.proc_req_valid && bus.proc_req_ready) begin
        check("accept_overlap", find_pending || (cyc < ins_free), 0);
        grant_log.push_back(0);
        x.req = bus.proc_request;
        x.ptr = bus.proc_data_ptr;
        exp_ins.push_back(x);
        ref_posted.push_back(bus.proc_request);
        acc_cyc = cyc;
        ins_free = cyc + 2 + GAP;
      end
      if (bus.net_msg_valid && bus.net_msg_ready) begin
        check("accept_overlap", find_pending || (cyc < ins_free), 0);
        grant_log.push_back(1);
        exp_find.push_back(bus.net_msg);
        find_pending = 1'b1;
        net_acc_cyc = cyc;
        e.msg = bus.net_msg;
        e.req = '0;
        if (prq_silent) e.kind = K_ERR;
        else begin
          idx = find_ref(bus.net_msg[111:88]);
          if (idx >= 0) begin
            e.kind = K_MATCH;
            e.req = ref_posted[idx];
            ref_posted.delete(idx);
          end else e.kind = K_UNEXP;
        end
        exp_out.push_back(e);
      end
      if (bus.prq_insert) begin
        ins_pulses++;
        if (exp_ins.size() == 0) fail_now("insert_spurious", "insert pulse with no accepted request");
        else begin
          x = exp_ins.pop_front();
          check("insert_request", bus.prq_request, x.req);
          check("insert_ptr", bus.prq_data_ptr, x.ptr);
          check("insert_time", cyc, acc_cyc + 1);
        end
      end
      if (bus.prq_find) begin
        find_pulses++;
        find_cyc = cyc;
        if (exp_find.size() == 0) fail_now("find_spurious", "find pulse with no accepted message");
        else begin
          check("find_message", bus.prq_message, exp_find.pop_front());
          check("find_time", cyc, net_acc_cyc + 1);
        end
      end
      if (bus.match_valid && !prev_mv) check("match_latency", cyc, resp_cyc + 1);
      if (prev_mv && !prev_mhs) begin
        check("match_hold_valid", bus.match_valid, 1);
        check("match_hold_req", bus.match_request, prev_mreq);
        check("match_hold_msg", bus.match_message, prev_mmsg);
      end
      if (prev_mhs) check("match_fall", {bus.match_valid, bus.busy}, 0);
      if (bus.match_valid && bus.match_ready) begin
        if (exp_out.size() == 0) fail_now("match_spurious", "match output with nothing expected");
        else begin
          e = exp_out.pop_front();
          check("match_kind", K_MATCH, e.kind);
          check("match_request", bus.match_request, e.req);
          check("match_message", bus.match_message, e.msg);
        end
        find_pending = 1'b0;
      end
      if (bus.unexp_valid && !prev_uv) check("unexp_latency", cyc, net_acc_cyc + 3);
      if (prev_uv && !prev_uhs) begin
        check("unexp_hold_valid", bus.unexp_valid, 1);
        check("unexp_hold_msg", bus.unexp_message, prev_umsg);
      end
      if (prev_uhs) check("unexp_fall", {bus.unexp_valid, bus.busy}, 0);
      if (bus.unexp_valid && bus.unexp_ready) begin
        if (exp_out.size() == 0) fail_now("unexp_spurious", "unexpected output with nothing expected");
        else begin
          e = exp_out.pop_front();
          check("unexp_kind", K_UNEXP, e.kind);
          check("unexp_message", bus.unexp_message, e.msg);
        end
        find_pending = 1'b0;
      end
      if (bus.err_timeout) begin
        err_count++;
        check("err_single", prev_err, 0);
        check("err_busy", bus.busy, 0);
        check("err_time", cyc, find_cyc + FTO + 2);
        if (exp_out.size() == 0) fail_now("err_spurious", "timeout with nothing expected");
        else begin
          e = exp_out.pop_front();
          check("err_kind", K_ERR, e.kind);
        end
        find_pending = 1'b0;
      end
      prev_mv = bus.match_valid;
      prev_mhs = bus.match_valid && bus.match_ready;
      prev_mreq = bus.match_request;
      prev_mmsg = bus.match_message;
      prev_uv = bus.unexp_valid;
      prev_uhs = bus.unexp_valid && bus.unexp_ready;
      prev_umsg = bus.unexp_message;
      prev_err = bus.err_timeout;
    end
  end

  task automatic wait_drain(string name);
    int w;
    w = 0;
    while ((proc_q.size() > 0 || net_q.size() > 0 || exp_out.size() > 0 || exp_ins.size() > 0 ||
            exp_find.size() > 0 || find_pending || cyc < ins_free) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 5000) fail_now(name, "scheduler did not drain within 5000 cycles");
    @(negedge clk);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_ctrl"}, {bus.prq_insert, bus.prq_find, bus.match_valid, bus.unexp_valid,
                           bus.busy, bus.err_timeout, bus.proc_req_ready, bus.net_msg_ready}, 0);
    check({tag, "_ops"}, {bus.prq_request, bus.prq_data_ptr, bus.match_request}, 0);
    check({tag, "_msg"}, bus.prq_message, 0);
  endtask

  initial begin : main
    int g0, p0, f0, e0, w;
    logic [7:0] c, s, t;
    bus.prq_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset_released");

    // Tie-break order straight after reset: processor first.
    for (int i = 0; i < 3; i++) begin
      push_proc({8'h00, 8'(8'h10 + i), 8'h00, 8'h00}, 32'h2000 + i);
      net_q.push_back(mk_msg(8'(8'h20 + i), 8'h00, 8'h00));
    end
    wait_drain("grant_drain");
    check("grant_order_0", grant_log[0], 0);
    check("grant_order_1", grant_log[1], 1);
    check("grant_order_2", grant_log[2], 0);

    // Insert then matching find.
    p0 = ins_pulses; f0 = find_pulses;
    push_proc(32'h00010203, 32'h1000);
    wait_drain("insert_drain");
    net_q.push_back(mk_msg(8'h01, 8'h02, 8'h03));
    wait_drain("match_drain");
    check("insert_pulses", ins_pulses - p0, 1);
    check("find_pulses", find_pulses - f0, 1);

    // Miss on a key nobody posted.
    net_q.push_back(mk_msg(8'hEE, 8'hEE, 8'hEE));
    wait_drain("miss_drain");

    // Full PRQ: only finds are granted.
    bus.prq_full = 1'b1;
    g0 = grant_log.size();
    push_proc(32'h00300000, 32'h3000);
    net_q.push_back(mk_msg(8'h31, 8'h00, 8'h00));
    net_q.push_back(mk_msg(8'h32, 8'h00, 8'h00));
    repeat (40) @(negedge clk);
    check("full_proc_waiting", proc_q.size(), 1);
    check("full_grants", grant_log.size() - g0, 2);
    bus.prq_full = 1'b0;
    wait_drain("full_drain");
    check("full_proc_after", grant_log[grant_log.size() - 1], 0);

    // Match output stalled for 10 cycles.
    ready_mode = 1;
    push_proc(32'h00400000, 32'h4000);
    wait_drain("stall_ins_drain");
    net_q.push_back(mk_msg(8'h40, 8'h00, 8'h00));
    w = 0;
    while (!bus.match_valid && w < 100) begin @(negedge clk); w++; end
    if (w >= 100) fail_now("stall_match_wait", "match_valid never rose");
    push_proc(32'h00410000, 32'h4100);
    g0 = grant_log.size();
    repeat (10) @(negedge clk);
    check("stall_no_grant", grant_log.size() - g0, 0);
    check("stall_valid", bus.match_valid, 1);
    ready_mode = 2;
    wait_drain("stall_drain");

    // Silent PRQ: timeout drops the message.
    e0 = err_count;
    prq_silent = 1'b1;
    net_q.push_back(mk_msg(8'h50, 8'h00, 8'h00));
    wait_drain("timeout_drain");
    check("timeout_pulses", err_count - e0, 1);

    // Reset while waiting on the PRQ.
    f0 = find_pulses;
    net_q.push_back(mk_msg(8'h51, 8'h00, 8'h00));
    w = 0;
    while (find_pulses == f0 && w < 100) begin @(negedge clk); w++; end
    if (w >= 100) fail_now("rst_find_wait", "find pulse never seen");
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy_before", bus.busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_zero("mid_reset");
    rst = 1'b0;
    e0 = err_count;
    repeat (20) @(negedge clk);
    check("mid_reset_no_err", err_count - e0, 0);
    prq_silent = 1'b0;

    // Randomized mix with output backpressure and PRQ-full episodes.
    ready_mode = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.prq_full = ($urandom_range(0, 3) == 0);
      c = 8'($urandom_range(0, 2));
      s = 8'($urandom_range(0, 2));
      t = 8'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) push_proc({8'($urandom), c, s, t}, $urandom);
      else net_q.push_back(mk_msg(c, s, t));
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    @(negedge clk);
    bus.prq_full = 1'b0;
    wait_drain("random_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded 50000 cycles");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/prq_sched.md
# prq_sched

Front-end scheduler for the posted receive queue (PRQ) in the message-matching path. It accepts posted receives from the Nios II processor and incoming message headers from the router, and serialises them onto the PRQ's single-operation `insert`/`find` interface. It waits out each PRQ operation, then routes every find result to either the match output or the unexpected-message output. Arbitration is round-robin, and the PRQ never sees overlapping commands.

## Interface
Parameters:
- `MSG_WIDTH`, 128, network message width.
- `INSERT_GAP`, 6, cycles held in INS_WAIT after an insert pulse, covering the PRQ insert FSM.
- `FIND_TIMEOUT`, 4095, maximum FIND_WAIT cycles before the scheduler aborts with an error.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `proc_req_valid` / `proc_req_ready`, in / out, 1 / 1: processor receive handshake.
- `proc_request`, in, 32: receive descriptor; [23:16] comm, [15:8] src, [7:0] tag.
- `proc_data_ptr`, in, 32: receive buffer pointer.
- `net_msg_valid` / `net_msg_ready`, in / out, 1 / 1: router message handshake.
- `net_msg`, in, MSG_WIDTH: message; [111:104] comm, [103:96] src, [95:88] tag.
- `prq_insert`, `prq_find`, out, 1: single-cycle command pulses to the PRQ.
- `prq_request`, `prq_data_ptr`, out, 32: insert operands, held stable.
- `prq_message`, out, MSG_WIDTH: find operand, held stable.
- `prq_found`, `prq_not_found`, `prq_full`, in, 1: PRQ status.
- `prq_posted_request`, in, 32: PRQ matched descriptor.
- `match_valid` / `match_ready`, out / in, 1 / 1: match output handshake.
- `match_request`, out, 32: matched descriptor.
- `match_message`, out, MSG_WIDTH: matching message.
- `unexp_valid` / `unexp_ready`, out / in, 1 / 1: unexpected-message output handshake.
- `unexp_message`, out, MSG_WIDTH: unmatched message.
- `busy`, out, 1: high whenever state != IDLE.
- `err_timeout`, out, 1: one-cycle pulse on a find timeout.

## Operation
- States:
  - IDLE
  - INS_ISSUE, INS_WAIT
  - FIND_ISSUE, FIND_WAIT
  - MATCH_OUT, UNEXP_OUT
- Arbitration in IDLE (combinational grant):
  - Processor is eligible when `proc_req_valid && !prq_full`.
  - Network is eligible when `net_msg_valid`.
  - One eligible source is granted.
  - If both are eligible, the source not in `last_grant` is granted.
  - `last_grant` resets to NET, so the processor wins the first tie.
- Ready: `proc_req_ready` / `net_msg_ready` are high only in IDLE and only for the granted source.
- On a transfer (valid && ready):
  - Operands are captured into `prq_*` registers.
  - `last_grant` is updated.
  - Processor transfer → INS_ISSUE; network transfer → FIND_ISSUE.
- INS_ISSUE:
  - `prq_insert`=1 for exactly one cycle → INS_WAIT.
  - INS_WAIT counts INSERT_GAP cycles → IDLE.
- FIND_ISSUE:
  - `prq_find`=1 for one cycle → FIND_WAIT; the cycle counter is cleared.
- FIND_WAIT:
  - On `prq_found`: capture `prq_posted_request` in that same cycle → MATCH_OUT.
  - Else on `prq_not_found` → UNEXP_OUT.
  - If both are asserted, found wins.
  - If the counter reaches FIND_TIMEOUT: pulse `err_timeout` → IDLE; the message is dropped.
- MATCH_OUT:
  - `match_valid`=1 with `match_request` / `match_message` stable.
  - On `match_ready` → IDLE.
- UNEXP_OUT:
  - `unexp_valid`=1 with `unexp_message` stable.
  - On `unexp_ready` → IDLE.
- `prq_message`, `prq_request`, `prq_data_ptr` hold their captured values until the next accepted transfer. The PRQ samples `message` combinationally throughout its search.
- `prq_full` blocks only the processor; finds proceed.

## Timing
- Reset values: every output 0, state IDLE, counters 0.
- `rst` asserted mid-operation: return to IDLE next edge; the captured item is discarded and no output pulses.
- Insert: accept at edge T, `prq_insert` high in cycle T+1, IDLE again at T+2+INSERT_GAP. Next accept no earlier than that cycle.
- Find: accept at T, `prq_find` in cycle T+1. A PRQ that is empty returns `prq_not_found` in cycle T+2, so `unexp_valid` is high from T+3.
- Result to output: `match_valid` / `unexp_valid` rise the cycle after `prq_found` / `prq_not_found`. They fall the cycle after the ready handshake.
- Throughput: at most one PRQ command in flight; no new grant while outputs are stalled.
- Counter widths: clog2(INSERT_GAP+1) for the insert gap, clog2(FIND_TIMEOUT+1) for the find counter; neither wraps.

## Test plan
- Insert then matching find:
  - Stimulus: proc request 0x00010203 with ptr 0x1000; then net_msg with comm=1, src=2, tag=3; PRQ model returns found.
  - Response: one `prq_insert` pulse, one `prq_find` pulse; `match_request`=0x00010203 and the full message on the match port.
- Find on empty PRQ:
  - Stimulus: net_msg arrives with the PRQ empty.
  - Response: `prq_not_found` at T+2, `unexp_valid` at T+3 with the identical message.
- Simultaneous valids:
  - Stimulus: proc and net valid together, three times back-to-back.
  - Response: grant order proc, net, proc; commands never overlap.
- `prq_full`=1 with both sources valid:
  - Response: only net is granted; `proc_req_ready` stays 0 until full drops.
- Output backpressure:
  - Stimulus: hold `match_ready`=0 for 10 cycles.
  - Response: `match_valid` and data stable throughout, no new grant; IDLE the cycle after ready.
- Find timeout and reset:
  - Stimulus: PRQ silent with FIND_TIMEOUT=8.
  - Response: `err_timeout` pulses once, then IDLE.
  - Stimulus: `rst` in FIND_WAIT.
  - Response: all outputs 0 on the next cycle.
